in_demux: RTL

//   Input-side counterpart of the output channel multiplexer. Accepts a time-division

---
 rtl/in_demux_if.sv | 28 ++
 rtl/in_demux.sv | 120 ++++++++++++
 2 files changed

// File: rtl/in_demux_if.sv
// Sample-stream bus between the TDM input source and the frame demultiplexer.
//   In1, in_valid, in_frame          : multiplexed sample stream (source -> demux)
//   Out1..Out3                        : assembled channel samples (demux -> filters)
//   out_valid, sync_err, overrun      : one-cycle status strobes (demux -> filters)
interface in_demux_if #(
    parameter int unsigned IN_W  = 11,
    parameter int unsigned OUT_W = 36
);
    logic signed [IN_W-1:0]  In1;
    logic                    in_valid;
    logic                    in_frame;
    logic signed [OUT_W-1:0] Out1;
    logic signed [OUT_W-1:0] Out2;
    logic signed [OUT_W-1:0] Out3;
    logic                    out_valid;
    logic                    sync_err;
    logic                    overrun;

    modport master (
        output In1, in_valid, in_frame,
        input  Out1, Out2, Out3, out_valid, sync_err, overrun
    );

    modport slave (
        input  In1, in_valid, in_frame,
        output Out1, Out2, Out3, out_valid, sync_err, overrun
    );
endinterface

// File: rtl/in_demux.sv
// TDM input demultiplexer: collects ch1/ch2/ch3 samples from the fast-rate stream,
// widens sfix11_En3 to sfix36_En27, and hands complete frames to the slow-rate
// filter sections through a one-deep frame buffer on the enb_1_3_0 phase.
//   clk        : system clock, rising edge
//   reset      : asynchronous reset, active-high
//   enb        : fast-rate clock enable
//   enb_1_3_0  : slow-rate phase enable, frame hand-off point
//   bus        : slave side of in_demux_if (sample stream in, frame and strobes out)
module in_demux #(
    parameter int unsigned IN_W   = 11,
    parameter int unsigned IN_FL  = 3,
    parameter int unsigned OUT_W  = 36,
    parameter int unsigned OUT_FL = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enb,
    input  logic        enb_1_3_0,
    in_demux_if.slave   bus
);
    localparam int unsigned SHIFT = OUT_FL - IN_FL;

    logic [1:0]              cnt;
    logic signed [IN_W-1:0]  s1;
    logic signed [IN_W-1:0]  s2;
    logic signed [OUT_W-1:0] f1, f2, f3;
    logic signed [OUT_W-1:0] out1, out2, out3;
    logic                    pending;
    logic                    out_valid_q, sync_err_q, overrun_q;

    logic accept_c, restart_c, complete_c, transfer_c;

    // Exact widening: sign-extend, then align the binary point.
    function automatic logic signed [OUT_W-1:0] widen(input logic signed [IN_W-1:0] x);
        logic signed [OUT_W-1:0] ext;
        ext = OUT_W'(x);
        return ext <<< SHIFT;
    endfunction

    // Per-cycle event decode; everything is qualified by enb.
    always_comb begin
        accept_c   = 1'b0;
        restart_c  = 1'b0;
        complete_c = 1'b0;
        transfer_c = 1'b0;
        accept_c   = enb & bus.in_valid;
        restart_c  = accept_c & bus.in_frame;
        complete_c = accept_c & ~bus.in_frame & (cnt == 2'd2);
        transfer_c = enb & enb_1_3_0 & pending;
    end

    // Slot counter, staging, frame buffer, output registers and strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= 2'd0;
            s1          <= '0;
            s2          <= '0;
            f1          <= '0;
            f2          <= '0;
            f3          <= '0;
            out1        <= '0;
            out2        <= '0;
            out3        <= '0;
            pending     <= 1'b0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= transfer_c;
            sync_err_q  <= restart_c & (cnt != 2'd0);
            // A frame completing on a transfer edge replaces a buffer that is being drained.
            overrun_q   <= complete_c & pending & ~transfer_c;

            if (accept_c) begin
                if (bus.in_frame) begin
                    s1  <= bus.In1;
                    cnt <= 2'd1;
                end else begin
                    case (cnt)
                        2'd0: begin
                            s1  <= bus.In1;
                            cnt <= 2'd1;
                        end
                        2'd1: begin
                            s2  <= bus.In1;
                            cnt <= 2'd2;
                        end
                        default: cnt <= 2'd0;
                    endcase
                end
            end

            // Output takes the old buffer contents before the buffer is overwritten.
            if (transfer_c) begin
                out1 <= f1;
                out2 <= f2;
                out3 <= f3;
            end

            if (complete_c) begin
                f1 <= widen(s1);
                f2 <= widen(s2);
                f3 <= widen(bus.In1);
            end

            if (complete_c) begin
                pending <= 1'b1;
            end else if (transfer_c) begin
                pending <= 1'b0;
            end
        end
    end

    assign bus.Out1      = out1;
    assign bus.Out2      = out2;
    assign bus.Out3      = out3;
    assign bus.out_valid = out_valid_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.overrun   = overrun_q;
endmodule
